demux_stream_1ton: RTL and testbench

//   Parametrised 1-to-N stream demultiplexer with valid/ready handshakes.
//   One input stream is steered to one of N output channels by a per-beat select.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_chan_fifo.sv | 77 +++++++
 rtl/demux_stream_1ton.sv | 105 ++++++++++
 tb/tb_demux_stream_1ton.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
//   Shared definitions for the 1-to-N stream demultiplexer.
//   DROP_CNT_W : width of the saturating dropped-beat counter.
//   sel_w(n)   : width of a select able to address n channels.
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam int DROP_CNT_W = 16;

    function automatic int sel_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// -----------------------------------------------------------------------------
// demux_chan_fifo
//   Single-clock FIFO used as the per-channel buffer of the demultiplexer.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     push, din  : write request and data (ignored while full)
//     full       : no free entry
//     pop        : read request, advances the head (ignored while empty)
//     dout       : registered head entry; holds its last value while empty
//     empty      : no valid entry
// -----------------------------------------------------------------------------
module demux_chan_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    output logic         full,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] dout_q, dout_d;
    logic         do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = dout_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        dout_d   = dout_q;
        // Preload the head that will be current after this edge. If every
        // stored entry is consumed this cycle, the new head is the beat being
        // written now, which is not in the array yet.
        if (wr_ptr_d != rd_ptr_d) begin
            if (do_push && (rd_ptr_d == wr_ptr_q)) begin
                dout_d = din;
            end else begin
                dout_d = mem_q[rd_ptr_d[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
        end
    end

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/demux_stream_1ton.sv
// -----------------------------------------------------------------------------
// demux_stream_1ton
//   Steers one input stream to one of N output channels using a per-beat
//   select. Each channel is buffered by its own FIFO so a stalled consumer
//   only blocks beats addressed to it.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     s_valid, s_ready, s_sel, s_data : input stream
//     m_valid[N], m_ready[N]          : per-channel output handshake
//     m_data[N*W]                     : channel i data on [i*W +: W]
//     drop_cnt                        : saturating count of out-of-range beats
//     err_sel                         : one-cycle pulse per dropped beat
//
//   Handshake: a beat transfers on a rising edge where valid & ready are both
//   high. s_ready depends only on s_sel and the addressed FIFO's full flag, so
//   there is no combinational path from any m_ready to s_ready. An
//   out-of-range select is always ready and the beat is discarded.
// -----------------------------------------------------------------------------
module demux_stream_1ton
    import demux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int W     = 8,
    parameter  int DEPTH = 2,
    localparam int SEL_W = sel_w(N)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SEL_W-1:0]      s_sel,
    input  logic [W-1:0]          s_data,
    output logic [N-1:0]          m_valid,
    input  logic [N-1:0]          m_ready,
    output logic [N*W-1:0]        m_data,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  err_sel
);

    logic [N-1:0]            sel_hit;
    logic                    sel_ok;
    logic                    sel_full;
    logic [N-1:0]            push;
    logic [N-1:0]            full;
    logic [N-1:0]            empty;
    logic                    drop;
    logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
    logic                    err_sel_q;

    // One-hot select decode. A select of N or more matches no channel,
    // which is how out-of-range beats are recognised.
    always_comb begin
        sel_hit  = '0;
        sel_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s_sel == SEL_W'(i)) begin
                sel_hit[i] = 1'b1;
                sel_full   = full[i];
            end
        end
    end

    assign sel_ok  = |sel_hit;
    assign s_ready = sel_ok ? ~sel_full : 1'b1;
    assign push    = sel_hit & {N{s_valid & s_ready}};
    assign drop    = s_valid & ~sel_ok;

    for (genvar g = 0; g < N; g++) begin : g_chan
        demux_chan_fifo #(
            .W     (W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push[g]),
            .din   (s_data),
            .full  (full[g]),
            .pop   (m_ready[g] & ~empty[g]),
            .dout  (m_data[g*W +: W]),
            .empty (empty[g])
        );
        assign m_valid[g] = ~empty[g];
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + DROP_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            err_sel_q  <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            err_sel_q  <= drop;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign err_sel  = err_sel_q;

endmodule

// File: tb/tb_demux_stream_1ton.sv
// -----------------------------------------------------------------------------
// tb_demux_stream_1ton
//   Bench for demux_stream_1ton. u4 (N=4) covers steering, backpressure,
//   full-with-pop, reset and random traffic against per-channel expected
//   queues; u3 (N=3) covers the out-of-range select and drop counter.
// -----------------------------------------------------------------------------
module tb_demux_stream_1ton;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- DUT N=4 ----------------
    logic        s_valid, s_ready;
    logic [1:0]  s_sel;
    logic [7:0]  s_data;
    logic [3:0]  m_valid, m_ready;
    logic [31:0] m_data;
    logic [15:0] drop_cnt;
    logic        err_sel;

    demux_stream_1ton #(.N(4), .W(8), .DEPTH(2)) u4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_sel    (s_sel),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .drop_cnt (drop_cnt),
        .err_sel  (err_sel)
    );

    // ---------------- DUT N=3 ----------------
    logic        s3_valid, s3_ready;
    logic [1:0]  s3_sel;
    logic [7:0]  s3_data;
    logic [2:0]  m3_valid, m3_ready;
    logic [23:0] m3_data;
    logic [15:0] drop3;
    logic        err3;

    demux_stream_1ton #(.N(3), .W(8), .DEPTH(2)) u3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s3_valid),
        .s_ready  (s3_ready),
        .s_sel    (s3_sel),
        .s_data   (s3_data),
        .m_valid  (m3_valid),
        .m_ready  (m3_ready),
        .m_data   (m3_data),
        .drop_cnt (drop3),
        .err_sel  (err3)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [4][$];
    int         chk_cnt  = 0;
    int         pass_cnt = 0;
    bit         rnd      = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every beat the DUT hands over must be the oldest outstanding beat of
    // that channel.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (m_valid[i] && m_ready[i]) begin
                check($sformatf("ch%0d_beat_expected", i), 32'(exp_q[i].size() != 0), 32'd1);
                if (exp_q[i].size() != 0) begin
                    check($sformatf("ch%0d_data", i), 32'(m_data[i*8 +: 8]), 32'(exp_q[i].pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called right after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [1:0] sel, input logic [7:0] d);
        int waited = 0;
        s_valid = 1'b1;
        s_sel   = sel;
        s_data  = d;
        @(negedge clk);
        while (!s_ready && waited < 64) begin
            @(posedge clk); #1;
            if (rnd) m_ready = 4'($urandom);
            @(negedge clk);
            waited++;
        end
        if (s_ready) exp_q[sel].push_back(d);
        else check("send_accept_timeout", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        if (rnd) m_ready = 4'($urandom);
    endtask

    task automatic drain();
        int cyc = 0;
        m_ready = 4'hF;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        check("drain_queues_empty", 32'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()), 32'd0);
        check("drain_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n    = 1'b0;
        s_valid  = 1'b0; s_sel  = '0; s_data  = '0; m_ready  = '0;
        s3_valid = 1'b0; s3_sel = '0; s3_data = '0; m3_ready = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        check("rst_err_sel", 32'(err_sel), 32'd0);
        check("rst_m3_valid", 32'(m3_valid), 32'd0);
        @(posedge clk); #1;

        // 1: reset mid-traffic, two beats parked in ch1 and two drops on u3
        m_ready  = 4'h0;
        s3_valid = 1'b1; s3_sel = 2'd3; s3_data = 8'h99;
        send(2'd1, 8'h11);
        send(2'd1, 8'h22);
        s3_valid = 1'b0;
        @(negedge clk);
        check("t1_ch1_held", 32'(m_valid), 32'h2);
        check("t1_drop3_before", 32'(drop3), 32'd2);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t1_async_m_valid", 32'(m_valid), 32'd0);
        check("t1_async_m_data", m_data, 32'd0);
        check("t1_async_drop3", 32'(drop3), 32'd0);
        for (int i = 0; i < 4; i++) exp_q[i].delete();
        @(posedge clk); @(posedge clk); #1;
        rst_n   = 1'b1;
        m_ready = 4'hF;
        repeat (4) @(negedge clk);
        check("t1_after_rst_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk); #1;

        // 2: steering, one beat per channel, latency one cycle
        m_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            logic [7:0] pat [4];
            pat[0] = 8'hA0; pat[1] = 8'hB1; pat[2] = 8'hC2; pat[3] = 8'hD3;
            s_valid = 1'b1; s_sel = 2'(k); s_data = pat[k];
            @(negedge clk);
            check($sformatf("t2_ready_sel%0d", k), 32'(s_ready), 32'd1);
            check($sformatf("t2_no_early_valid_sel%0d", k), 32'(m_valid), 32'd0);
            exp_q[k].push_back(pat[k]);
            @(posedge clk); #1;
            s_valid = 1'b0;
            @(negedge clk);
            check($sformatf("t2_onehot_sel%0d", k), 32'(m_valid), 32'(4'b1 << k));
            @(posedge clk); #1;
        end
        drain();

        // 3: backpressure on ch2
        m_ready = 4'b1011;
        send(2'd2, 8'h31);
        send(2'd2, 8'h32);
        s_valid = 1'b1; s_sel = 2'd2; s_data = 8'h33;
        @(negedge clk);
        check("t3_ch2_full_not_ready", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        s_sel = 2'd0; s_data = 8'h40;
        @(negedge clk);
        check("t3_ch0_ready_while_ch2_full", 32'(s_ready), 32'd1);
        exp_q[0].push_back(8'h40);
        @(posedge clk); #1;
        s_sel = 2'd2; s_data = 8'h33;
        @(negedge clk);
        check("t3_ch2_still_full", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        m_ready = 4'hF;
        @(negedge clk);
        check("t3_no_mready_to_sready_path", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t3_ready_after_pop", 32'(s_ready), 32'd1);
        exp_q[2].push_back(8'h33);
        @(posedge clk); #1;
        s_valid = 1'b0;
        drain();

        // 4: ch1 full, pop and push in the same period
        m_ready = 4'b1101;
        send(2'd1, 8'h41);
        send(2'd1, 8'h42);
        s_valid = 1'b1; s_sel = 2'd1; s_data = 8'h43;
        m_ready = 4'hF;
        @(negedge clk);
        check("t4_full_pop_no_bypass", 32'(s_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_ready_next_cycle", 32'(s_ready), 32'd1);
        exp_q[1].push_back(8'h43);
        @(posedge clk); #1;
        s_valid = 1'b0;
        m_ready = 4'b1101;
        @(negedge clk);
        check("t4_occupancy_one_valid", 32'(m_valid), 32'h2);
        check("t4_head_data", 32'(m_data[15:8]), 32'h43);
        check("t4_occupancy_one_ready", 32'(s_ready), 32'd1);
        @(posedge clk); #1;
        drain();

        // 5: random traffic with random per-channel backpressure
        rnd = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
        end
        rnd = 1'b0;
        drain();

        // u3 in-range sanity: ch2 of a 3-channel instance
        m3_ready = 3'b000;
        s3_valid = 1'b1; s3_sel = 2'd2; s3_data = 8'h77;
        @(posedge clk); #1;
        s3_valid = 1'b0;
        @(negedge clk);
        check("t6_u3_ch2_valid", 32'(m3_valid), 32'h4);
        check("t6_u3_ch2_data", 32'(m3_data[23:16]), 32'h77);
        check("t6_u3_no_err", 32'(err3), 32'd0);
        @(posedge clk); #1;
        m3_ready = 3'b111;
        @(posedge clk); #1;

        // 6: out-of-range select on the N=3 instance
        s3_valid = 1'b1; s3_sel = 2'd3; s3_data = 8'h5A;
        @(negedge clk);
        check("t6_bad_sel_ready", 32'(s3_ready), 32'd1);
        check("t6_err_not_early", 32'(err3), 32'd0);
        @(posedge clk); #1;
        s3_valid = 1'b0;
        @(negedge clk);
        check("t6_err_pulse", 32'(err3), 32'd1);
        check("t6_drop_one", 32'(drop3), 32'd1);
        check("t6_no_m_valid", 32'(m3_valid), 32'd0);
        @(negedge clk);
        check("t6_err_single", 32'(err3), 32'd0);
        @(posedge clk); #1;
        s3_valid = 1'b1;
        repeat (65533) @(posedge clk);
        @(negedge clk);
        check("t6_drop_fffe", 32'(drop3), 32'hFFFE);
        check("t6_err_streaming", 32'(err3), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("t6_drop_fffF", 32'(drop3), 32'hFFFF);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("t6_drop_saturated", 32'(drop3), 32'hFFFF);
        s3_valid = 1'b0;
        @(negedge clk);
        check("t6_err_clear", 32'(err3), 32'd0);
        check("t6_u3_m_valid", 32'(m3_valid), 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
